// File: rtl/regfile_access_ctrl.sv
// Arbitrates a two-port read / one-port write interface onto a BRAM register file
// with x0 hardwired to zero, a one-cycle read latency and bounded read starvation.
module regfile_access_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_req_valid,
  output logic             rd_req_ready,
  input  logic [4:0]       ra0,
  input  logic [4:0]       ra1,
  output logic             rd_resp_valid,
  input  logic             rd_resp_ready,
  output logic [WIDTH-1:0] rd0,
  output logic [WIDTH-1:0] rd1,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [4:0]       wa,
  input  logic [WIDTH-1:0] wd,
  output logic [4:0]       rf_ra0,
  output logic [4:0]       rf_ra1,
  output logic [4:0]       rf_wa,
  output logic             rf_we,
  output logic [WIDTH-1:0] rf_wd,
  input  logic [WIDTH-1:0] rf_rd0,
  input  logic [WIDTH-1:0] rf_rd1
);

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] STARVE_MAX = CW'(4);

  typedef enum logic [1:0] {IDLE, READ_WAIT, RESP_HOLD} state_e;

  state_e           state_q;
  logic [AW-1:0]    ra0_q, ra1_q;
  logic [WIDTH-1:0] hold0_q, hold1_q;
  logic [CW-1:0]    starve_cnt_q;

  logic             read_eligible;
  logic             wfire_nz;
  logic             rd_fire;
  logic [WIDTH-1:0] live0, live1;

  assign read_eligible = ((state_q == IDLE) || rd_resp_ready) && !rst;
  assign wr_ready      = !rst && !((starve_cnt_q == STARVE_MAX) && rd_req_valid && read_eligible);
  assign wfire_nz      = wr_valid && wr_ready && (wa != '0);
  assign rd_req_ready  = read_eligible && !wfire_nz;
  assign rd_fire       = rd_req_valid && rd_req_ready;

  assign rf_ra0 = ra0;
  assign rf_ra1 = ra1;
  assign rf_wa  = wa;
  assign rf_wd  = wd;
  assign rf_we  = wfire_nz;

  // x0 reads as zero regardless of what the file holds at that address
  assign live0 = (ra0_q == '0) ? '0 : rf_rd0;
  assign live1 = (ra1_q == '0) ? '0 : rf_rd1;

  assign rd_resp_valid = !rst && (state_q != IDLE);

  always_comb begin
    rd0 = '0;
    rd1 = '0;
    if (!rst) begin
      case (state_q)
        READ_WAIT: begin
          rd0 = live0;
          rd1 = live1;
        end
        RESP_HOLD: begin
          rd0 = hold0_q;
          rd1 = hold1_q;
        end
        default: begin
          rd0 = '0;
          rd1 = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ra0_q        <= '0;
      ra1_q        <= '0;
      hold0_q      <= '0;
      hold1_q      <= '0;
      starve_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_fire) begin
            state_q <= READ_WAIT;
            ra0_q   <= ra0;
            ra1_q   <= ra1;
          end
        end
        READ_WAIT: begin
          if (rd_resp_ready) begin
            if (rd_fire) begin
              state_q <= READ_WAIT;
              ra0_q   <= ra0;
              ra1_q   <= ra1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            // file output is only valid this one cycle, so park it
            hold0_q <= live0;
            hold1_q <= live1;
            state_q <= RESP_HOLD;
          end
        end
        RESP_HOLD: begin
          if (rd_resp_ready) begin
            if (rd_fire) begin
              state_q <= READ_WAIT;
              ra0_q   <= ra0;
              ra1_q   <= ra1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      // counts nonzero writes that stall a waiting, otherwise-issuable read
      if (rd_fire || !rd_req_valid || !read_eligible) begin
        starve_cnt_q <= '0;
      end else if (wfire_nz && (starve_cnt_q != STARVE_MAX)) begin
        starve_cnt_q <= CW'(starve_cnt_q + CW'(1));
      end
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl: BRAM model, queue-based response
// model and directed plus randomized scenarios.
module tb_regfile_access_ctrl;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, rd_req_valid, rd_req_ready, rd_resp_valid, rd_resp_ready;
  logic         wr_valid, wr_ready, rf_we;
  logic [4:0]   ra0, ra1, wa, rf_ra0, rf_ra1, rf_wa;
  logic [W-1:0] rd0, rd1, wd, rf_wd, rf_rd0, rf_rd1;

  regfile_access_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .ra0(ra0), .ra1(ra1),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd0(rd0), .rd1(rd1),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wa(wa), .wd(wd),
    .rf_ra0(rf_ra0), .rf_ra1(rf_ra1), .rf_wa(rf_wa), .rf_we(rf_we), .rf_wd(rf_wd),
    .rf_rd0(rf_rd0), .rf_rd1(rf_rd1)
  );

  function automatic logic [W-1:0] seed(int i);
    return 32'hA5A5_0000 | W'(i);
  endfunction

  // BRAM register file: registered read, no read while writing
  logic [W-1:0] bram [32];
  logic         init_phase;
  always @(posedge clk) begin
    if (init_phase) begin
      for (int i = 0; i < 32; i++) bram[i] <= seed(i);
    end else if (rf_we) begin
      bram[rf_wa] <= rf_wd;
    end else begin
      rf_rd0 <= bram[rf_ra0];
      rf_rd1 <= bram[rf_ra1];
    end
  end

  // reference model: architectural register contents plus outstanding responses
  logic [W-1:0]   m_mem [32];
  logic [2*W-1:0] pq [$];
  int             starve;
  int             n_checks = 0;
  int             n_pass = 0;

  logic         e_elig, e_wrdy, e_wnz, e_rrdy, e_rfire, e_valid;
  logic [W-1:0] e_d0, e_d1;

  task automatic calc();
    e_elig  = !rst && (pq.size() == 0 || rd_resp_ready);
    e_wrdy  = !rst && !(starve == 4 && rd_req_valid && e_elig);
    e_wnz   = wr_valid && e_wrdy && (wa != 5'd0);
    e_rrdy  = e_elig && !e_wnz;
    e_rfire = rd_req_valid && e_rrdy;
    e_valid = !rst && (pq.size() > 0);
    e_d0    = e_valid ? pq[0][2*W-1:W] : '0;
    e_d1    = e_valid ? pq[0][W-1:0] : '0;
  endtask

  task automatic settle();
    #1;
    calc();
  endtask

  task automatic tick();
    logic [W-1:0] v0, v1;
    @(posedge clk);
    calc();
    if (rst) begin
      pq.delete();
      starve = 0;
    end else begin
      if (e_valid && rd_resp_ready) void'(pq.pop_front());
      if (e_rfire) begin
        v0 = (ra0 == 5'd0) ? '0 : m_mem[ra0];
        v1 = (ra1 == 5'd0) ? '0 : m_mem[ra1];
        pq.push_back({v0, v1});
      end
      if (e_wnz) m_mem[wa] = wd;
      if (e_rfire || !rd_req_valid || !e_elig) starve = 0;
      else if (e_wnz && starve < 4) starve = starve + 1;
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    rd_req_valid = 1'b0; wr_valid = 1'b0; rd_resp_ready = 1'b1;
    wa = 5'd0; wd = '0; ra0 = 5'd0; ra1 = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; init_phase = 1'b1;
    rd_req_valid = 1'b1; wr_valid = 1'b1; wa = 5'd5; wd = 32'h1234_5678; rd_resp_ready = 1'b1;
    settle();
    n_checks++; if (rd_resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %0b want 0", rd_resp_valid); else n_pass++;
    n_checks++; if (rd_req_ready !== 1'b0) $display("FAIL reset_req_ready got %0b want 0", rd_req_ready); else n_pass++;
    n_checks++; if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready got %0b want 0", wr_ready); else n_pass++;
    n_checks++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we got %0b want 0", rf_we); else n_pass++;
    tick();
    init_phase = 1'b0;
    settle();
    n_checks++; if (rd_resp_valid !== 1'b0) $display("FAIL reset2_resp_valid got %0b want 0", rd_resp_valid); else n_pass++;
    tick();
    rst = 1'b0; idle_in();
    settle();
    n_checks++; if (rd_resp_valid !== 1'b0) $display("FAIL post_reset_valid got %0b want 0", rd_resp_valid); else n_pass++;
    n_checks++; if (wr_ready !== 1'b1) $display("FAIL post_reset_wr_ready got %0b want 1", wr_ready); else n_pass++;
    tick();
  endtask

  task automatic test_write_then_read();
    idle_in(); wr_valid = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
    settle();
    n_checks++; if (rf_we !== 1'b1) $display("FAIL wr_rf_we got %0b want 1", rf_we); else n_pass++;
    n_checks++; if ({rf_wa, rf_wd} !== {5'd5, 32'hDEAD_BEEF}) $display("FAIL wr_rf_bus got %0d/%h want 5/deadbeef", rf_wa, rf_wd); else n_pass++;
    tick();
    idle_in(); rd_req_valid = 1'b1; ra0 = 5'd5; ra1 = 5'd0;
    settle();
    n_checks++; if (rd_req_ready !== 1'b1) $display("FAIL rd_req_ready got %0b want 1", rd_req_ready); else n_pass++;
    tick();
    idle_in();
    settle();
    n_checks++; if (rd_resp_valid !== 1'b1) $display("FAIL wtr_valid got %0b want 1", rd_resp_valid); else n_pass++;
    n_checks++; if (rd0 !== 32'hDEAD_BEEF) $display("FAIL wtr_rd0 got %h want deadbeef", rd0); else n_pass++;
    n_checks++; if (rd1 !== '0) $display("FAIL wtr_rd1_x0 got %h want 0", rd1); else n_pass++;
    tick();
  endtask

  task automatic test_conflict();
    logic [W-1:0] v3;
    v3 = $urandom;
    idle_in(); wr_valid = 1'b1; wa = 5'd3; wd = v3; rd_req_valid = 1'b1; ra0 = 5'd3; ra1 = 5'd5;
    settle();
    n_checks++; if (rf_we !== 1'b1) $display("FAIL conf_rf_we got %0b want 1", rf_we); else n_pass++;
    n_checks++; if (rd_req_ready !== 1'b0) $display("FAIL conf_stall got %0b want 0", rd_req_ready); else n_pass++;
    tick();
    wr_valid = 1'b0;
    settle();
    n_checks++; if (rd_req_ready !== 1'b1) $display("FAIL conf_next_ready got %0b want 1", rd_req_ready); else n_pass++;
    tick();
    wr_valid = 1'b1; wa = 5'd0; wd = $urandom; ra0 = 5'd5; ra1 = 5'd3;
    settle();
    n_checks++; if ({rd_resp_valid, rd0, rd1} !== {1'b1, v3, 32'hDEAD_BEEF}) $display("FAIL conf_resp got %0b %h %h want 1 %h deadbeef", rd_resp_valid, rd0, rd1, v3); else n_pass++;
    n_checks++; if ({rf_we, rd_req_ready} !== 2'b01) $display("FAIL x0_write got we=%0b rdy=%0b want 0 1", rf_we, rd_req_ready); else n_pass++;
    tick();
    idle_in();
    settle();
    n_checks++; if ({rd_resp_valid, rd0, rd1} !== {1'b1, 32'hDEAD_BEEF, v3}) $display("FAIL x0_read_resp got %0b %h %h want 1 deadbeef %h", rd_resp_valid, rd0, rd1, v3); else n_pass++;
    tick();
  endtask

  task automatic test_hold();
    logic [W-1:0] old_v, new_v;
    old_v = $urandom; new_v = ~old_v;
    idle_in(); wr_valid = 1'b1; wa = 5'd7; wd = old_v;
    tick();
    idle_in(); rd_req_valid = 1'b1; ra0 = 5'd7; rd_resp_ready = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      wr_valid = 1'b1; wa = 5'd7; wd = new_v; rd_req_valid = 1'b1; ra0 = 5'd7; rd_resp_ready = 1'b0;
      settle();
      n_checks++; if ({rd_resp_valid, rd0} !== {1'b1, old_v}) $display("FAIL hold_c%0d got %0b %h want 1 %h", c, rd_resp_valid, rd0, old_v); else n_pass++;
      n_checks++; if ({rf_we, rd_req_ready} !== 2'b10) $display("FAIL hold_hs_c%0d got we=%0b rdy=%0b want 1 0", c, rf_we, rd_req_ready); else n_pass++;
      tick();
    end
    wr_valid = 1'b0; rd_resp_ready = 1'b1;
    settle();
    n_checks++; if ({rd_resp_valid, rd0, rd_req_ready} !== {1'b1, old_v, 1'b1}) $display("FAIL hold_release got %0b %h %0b want 1 %h 1", rd_resp_valid, rd0, rd_req_ready, old_v); else n_pass++;
    tick();
    idle_in();
    settle();
    n_checks++; if ({rd_resp_valid, rd0} !== {1'b1, new_v}) $display("FAIL post_write_read got %0b %h want 1 %h", rd_resp_valid, rd0, new_v); else n_pass++;
    tick();
  endtask

  task automatic test_starve();
    logic [W-1:0] base;
    base = $urandom;
    for (int i = 0; i < 5; i++) begin
      rd_req_valid = 1'b1; ra0 = 5'd9; ra1 = 5'd0; rd_resp_ready = 1'b1;
      wr_valid = 1'b1; wa = 5'd9; wd = base + W'(i);
      settle();
      if (i < 4) begin
        n_checks++; if ({wr_ready, rf_we, rd_req_ready} !== 3'b110) $display("FAIL starve_w%0d got wr=%0b we=%0b rd=%0b want 1 1 0", i, wr_ready, rf_we, rd_req_ready); else n_pass++;
      end else begin
        n_checks++; if ({wr_ready, rf_we, rd_req_ready} !== 3'b001) $display("FAIL starve_issue got wr=%0b we=%0b rd=%0b want 0 0 1", wr_ready, rf_we, rd_req_ready); else n_pass++;
      end
      tick();
    end
    wd = base + W'(5);
    settle();
    n_checks++; if ({rd_resp_valid, rd0} !== {1'b1, base + W'(3)}) $display("FAIL starve_resp got %0b %h want 1 %h", rd_resp_valid, rd0, base + W'(3)); else n_pass++;
    n_checks++; if ({wr_ready, rf_we} !== 2'b11) $display("FAIL starve_resume got wr=%0b we=%0b want 1 1", wr_ready, rf_we); else n_pass++;
    tick();
    idle_in();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] vals [4];
    for (int k = 1; k < 4; k++) begin
      vals[k] = $urandom;
      idle_in(); wr_valid = 1'b1; wa = 5'(k); wd = vals[k];
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      idle_in();
      if (k < 3) begin
        rd_req_valid = 1'b1; ra0 = 5'(k + 1); ra1 = 5'(3 - k);
      end
      settle();
      if (k < 3) begin
        n_checks++; if (rd_req_ready !== 1'b1) $display("FAIL b2b_ready_%0d got %0b want 1", k, rd_req_ready); else n_pass++;
      end
      if (k > 0) begin
        n_checks++; if ({rd_resp_valid, rd0, rd1} !== {1'b1, vals[k], vals[4-k]}) $display("FAIL b2b_resp_%0d got %0b %h %h want 1 %h %h", k, rd_resp_valid, rd0, rd1, vals[k], vals[4-k]); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    idle_in(); rd_req_valid = 1'b1; ra0 = 5'd5; ra1 = 5'd3;
    tick();
    rst = 1'b1; wr_valid = 1'b1; wa = 5'd4;
    settle();
    n_checks++; if (rd_resp_valid !== 1'b0) $display("FAIL rstmid_valid got %0b want 0", rd_resp_valid); else n_pass++;
    tick();
    settle();
    n_checks++; if ({rd_resp_valid, rd_req_ready, wr_ready, rf_we} !== 4'b0000) $display("FAIL rstmid_outs got %b want 0000", {rd_resp_valid, rd_req_ready, wr_ready, rf_we}); else n_pass++;
    tick();
    rst = 1'b0; idle_in();
    settle();
    n_checks++; if ({rd_resp_valid, rd_req_ready} !== 2'b01) $display("FAIL rstmid_release got %b want 01", {rd_resp_valid, rd_req_ready}); else n_pass++;
    rd_req_valid = 1'b1; ra0 = 5'd5; rd_resp_ready = 1'b0;
    tick();
    rd_req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; rd_resp_ready = 1'b0;
    settle();
    n_checks++; if (rd_resp_valid !== 1'b0) $display("FAIL rsthold_release got %0b want 0", rd_resp_valid); else n_pass++;
    tick();
    idle_in();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst           = ($urandom_range(0, 79) == 0);
      rd_req_valid  = ($urandom_range(0, 9) < ((n % 128) < 64 ? 6 : 9));
      ra0           = 5'($urandom_range(0, 7));
      ra1           = 5'($urandom_range(0, 7));
      wr_valid      = ($urandom_range(0, 9) < ((n % 128) < 64 ? 4 : 9));
      wa            = 5'($urandom_range(0, 7));
      wd            = $urandom;
      rd_resp_ready = ($urandom_range(0, 9) < 7);
      settle();
      n_checks++; if (rd_req_ready !== e_rrdy) $display("FAIL rnd_req_ready n=%0d got %0b want %0b", n, rd_req_ready, e_rrdy); else n_pass++;
      n_checks++; if (wr_ready !== e_wrdy) $display("FAIL rnd_wr_ready n=%0d got %0b want %0b", n, wr_ready, e_wrdy); else n_pass++;
      n_checks++; if (rf_we !== e_wnz) $display("FAIL rnd_rf_we n=%0d got %0b want %0b", n, rf_we, e_wnz); else n_pass++;
      n_checks++; if (rd_resp_valid !== e_valid) $display("FAIL rnd_valid n=%0d got %0b want %0b", n, rd_resp_valid, e_valid); else n_pass++;
      if (e_valid) begin
        n_checks++; if ({rd0, rd1} !== {e_d0, e_d1}) $display("FAIL rnd_data n=%0d got %h %h want %h %h", n, rd0, rd1, e_d0, e_d1); else n_pass++;
      end
      tick();
    end
    rst = 1'b0; idle_in();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = seed(i);
    starve = 0;
    rst = 1'b1; init_phase = 1'b1; idle_in();
    test_reset();
    test_write_then_read();
    test_conflict();
    test_hold();
    test_starve();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
